ddc_tune_ctrl: RTL and testbench

Sequencing controller for the real-to-IQ downconverter's NCO. It owns the 32-bit phase accumulator and its phase step. It accepts retune requests over a valid/ready handshake and applies them either immediately (with phase clear) or at the next phase wrap (phase-continuous). While the mixer output is invalid after enable or retune, it gates downstream data valid for a settle window.

---
 rtl/ddc_ctrl_pkg.sv | 19 +
 rtl/nco_phase_acc.sv | 30 +++
 rtl/ddc_tune_ctrl.sv | 144 ++++++++++++++
 tb/tb_ddc_tune_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ddc_ctrl_pkg.sv
// Shared types and helpers for the downconverter NCO tuning controller.
// Holds the controller state encoding and the phase-step calculation.
package ddc_ctrl_pkg;

    localparam int PHASE_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        RUN,
        APPLY,
        WAIT_WRAP
    } state_t;

    function automatic logic [PHASE_W-1:0] calc_phase_step(input real fs, input real f);
        return PHASE_W'(int'(f * (2.0 ** 32) / fs));
    endfunction

endpackage

// File: rtl/nco_phase_acc.sv
// 32-bit NCO phase accumulator with clear, hold and carry-out.
// Clear has priority over accumulate; the carry flag is only valid while accumulating.
module nco_phase_acc
    import ddc_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clr,
    input  logic               i_acc,
    input  logic [PHASE_W-1:0] i_step,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_carry
);

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W:0]   w_sum;

    assign w_sum   = {1'b0, r_phase} + {1'b0, i_step};
    assign o_carry = i_acc && w_sum[PHASE_W];
    assign o_phase = r_phase;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_phase <= '0;
        end else if (i_acc) begin
            r_phase <= w_sum[PHASE_W-1:0];
        end
    end

endmodule

// File: rtl/ddc_tune_ctrl.sv
// NCO tuning controller: owns the phase step, sequences retunes and
// blanks downstream valid while the mixer settles.
module ddc_tune_ctrl
    import ddc_ctrl_pkg::*;
#(
    parameter real              FS            = 800.0e6,
    parameter real              F_SYM         = 10.0e6,
    parameter logic [PHASE_W-1:0] DEFAULT_STEP = calc_phase_step(FS, 0.25 * F_SYM),
    parameter int               SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic               cfg_sync,
    output logic [PHASE_W-1:0] nco_phase,
    output logic               nco_clr,
    output logic               out_valid,
    output logic               tuned,
    output logic [PHASE_W-1:0] step_active
);

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

    state_t             r_state;
    state_t             w_nxt;
    logic [PHASE_W-1:0] r_step;
    logic [PHASE_W-1:0] w_step_nxt;
    logic [PHASE_W-1:0] r_pend;
    logic [PHASE_W-1:0] w_pend_nxt;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_nxt;
    logic               r_clr;
    logic               r_out_valid;
    logic               r_tuned;
    logic               w_xfer;
    logic               w_enter;
    logic               w_acc_clr;
    logic               w_acc_en;
    logic               w_carry;

    assign cfg_ready   = (r_state == IDLE) || (r_state == RUN);
    assign w_xfer      = cfg_valid && cfg_ready;
    assign nco_clr     = r_clr;
    assign out_valid   = r_out_valid;
    assign tuned       = r_tuned;
    assign step_active = r_step;

    nco_phase_acc u_acc (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_acc_clr),
        .i_acc   (w_acc_en),
        .i_step  (r_step),
        .o_phase (nco_phase),
        .o_carry (w_carry)
    );

    always_comb begin
        w_nxt      = r_state;
        w_step_nxt = r_step;
        w_pend_nxt = r_pend;
        w_cnt_nxt  = r_cnt;
        w_enter    = 1'b0;
        w_acc_clr  = 1'b0;
        w_acc_en   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_acc_clr = 1'b1;
                if (w_xfer) w_step_nxt = cfg_step;
                if (en) w_enter = 1'b1;
            end
            SETTLE: begin
                w_acc_en  = 1'b1;
                w_cnt_nxt = r_cnt - 8'd1;
                if (r_cnt == 8'd1) w_nxt = RUN;
            end
            RUN: begin
                w_acc_en = 1'b1;
                if (w_xfer) begin
                    if (!en) begin
                        w_step_nxt = cfg_step;
                    end else begin
                        w_pend_nxt = cfg_step;
                        // A zero step never wraps, so a sync retune would hang
                        w_nxt = (cfg_sync && r_step != '0) ? WAIT_WRAP : APPLY;
                    end
                end
            end
            APPLY: begin
                w_acc_clr  = 1'b1;
                w_step_nxt = r_pend;
                w_enter    = 1'b1;
            end
            WAIT_WRAP: begin
                w_acc_en = 1'b1;
                if (w_carry) begin
                    w_step_nxt = r_pend;
                    w_enter    = 1'b1;
                end
            end
            default: w_nxt = IDLE;
        endcase
        if (w_enter) begin
            if (SETTLE_CYCLES == 0) begin
                w_nxt = RUN;
            end else begin
                w_nxt     = SETTLE;
                w_cnt_nxt = SETTLE_INIT;
            end
        end
        if (!en && r_state != IDLE) begin
            w_nxt      = IDLE;
            w_acc_clr  = 1'b1;
            w_acc_en   = 1'b0;
            w_pend_nxt = '0;
            w_cnt_nxt  = '0;
            if (!(r_state == RUN && w_xfer)) w_step_nxt = r_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_step      <= DEFAULT_STEP;
            r_pend      <= '0;
            r_cnt       <= '0;
            r_clr       <= 1'b0;
            r_out_valid <= 1'b0;
            r_tuned     <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_step      <= w_step_nxt;
            r_pend      <= w_pend_nxt;
            r_cnt       <= w_cnt_nxt;
            r_clr       <= (w_nxt == APPLY);
            r_out_valid <= (w_nxt == RUN) || (w_nxt == WAIT_WRAP);
            r_tuned     <= (w_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_ddc_tune_ctrl.sv
// Scoreboard bench for ddc_tune_ctrl: stimulus queues expected outputs per
// clock, a negedge monitor pops and compares them against the DUT.
module tb_ddc_tune_ctrl;

    localparam logic [31:0] D  = 32'd13421773;
    localparam logic [31:0] S2 = 32'd26843546;
    localparam logic [31:0] S3 = 32'd6710886;

    typedef struct {
        string       nm;
        logic [31:0] ph;
        logic        clr;
        logic        ov;
        logic        tu;
        logic        rdy;
        logic [31:0] st;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_step;
    logic        cfg_sync;
    logic [31:0] nco_phase;
    logic        nco_clr;
    logic        out_valid;
    logic        tuned;
    logic [31:0] step_active;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ph;

    ddc_tune_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_step    (cfg_step),
        .cfg_sync    (cfg_sync),
        .nco_phase   (nco_phase),
        .nco_clr     (nco_clr),
        .out_valid   (out_valid),
        .tuned       (tuned),
        .step_active (step_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (nco_phase !== e.ph || nco_clr !== e.clr || out_valid !== e.ov ||
                tuned !== e.tu || cfg_ready !== e.rdy || step_active !== e.st) begin
                n_fail++;
                $display("FAIL %s: got ph=%0d clr=%b ov=%b tu=%b rdy=%b st=%0d, want ph=%0d clr=%b ov=%b tu=%b rdy=%b st=%0d",
                         e.nm, nco_phase, nco_clr, out_valid, tuned, cfg_ready, step_active,
                         e.ph, e.clr, e.ov, e.tu, e.rdy, e.st);
            end
        end
    end

    task automatic step(input string nm, input logic [31:0] eph, input logic eclr,
                        input logic eov, input logic etu, input logic erdy,
                        input logic [31:0] est);
        @(posedge clk);
        q.push_back('{nm, eph, eclr, eov, etu, erdy, est});
        #1;
    endtask

    task automatic bring_up();
        reset = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        step("reset", 0, 0, 0, 0, 1, D);
        reset = 1'b0; en = 1'b1;
        ph = 0;
        for (int k = 0; k < 4; k++) begin
            step("settle", ph, 0, 0, 0, 0, D);
            ph += D;
        end
        step("run_entry", ph, 0, 1, 1, 1, D);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_step = '0; cfg_sync = 1'b0;
        ph = '0;
        #1;
        // Enable after reset, run through the first phase wrap
        bring_up();
        for (int k = 5; k <= 325; k++) begin
            ph += D;
            if (k == 320) step("first_wrap", 32'd64, 0, 1, 1, 1, D);
            else          step("run_acc", ph, 0, 1, 1, 1, D);
        end

        // Immediate retune from RUN
        cfg_valid = 1'b1; cfg_step = S2; cfg_sync = 1'b0;
        ph += D;
        step("imm_apply", ph, 1, 0, 0, 0, D);
        cfg_valid = 1'b0;
        step("imm_clr", 0, 0, 0, 0, 0, S2);
        step("imm_settle1", S2, 0, 0, 0, 0, S2);
        step("imm_settle2", 32'd53687092, 0, 0, 0, 0, S2);
        step("imm_settle3", 32'd80530638, 0, 0, 0, 0, S2);
        step("imm_run", 32'd107374184, 0, 1, 1, 1, S2);
        step("imm_run2", 32'd134217730, 0, 1, 1, 1, S2);

        // Phase-continuous retune at the next wrap
        bring_up();
        cfg_valid = 1'b1; cfg_step = S3; cfg_sync = 1'b1;
        ph += D;
        step("sync_req", ph, 0, 1, 0, 0, D);
        cfg_valid = 1'b0;
        for (int k = 6; k < 320; k++) begin
            ph += D;
            step("wait_wrap", ph, 0, 1, 0, 0, D);
        end
        step("sync_wrap", 32'd64, 0, 0, 0, 0, S3);
        ph = 32'd64;
        for (int j = 1; j < 4; j++) begin
            ph += S3;
            step("sync_settle", ph, 0, 0, 0, 0, S3);
        end
        step("sync_run", 32'd26843608, 0, 1, 1, 1, S3);
        step("sync_run2", 32'd33554494, 0, 1, 1, 1, S3);

        // Zero step: phase freezes, sync retune degrades to immediate
        reset = 1'b1; en = 1'b0;
        step("reset2", 0, 0, 0, 0, 1, D);
        reset = 1'b0;
        cfg_valid = 1'b1; cfg_step = 32'd0; cfg_sync = 1'b1;
        step("idle_zero", 0, 0, 0, 0, 1, 0);
        cfg_valid = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) step("z_settle", 0, 0, 0, 0, 0, 0);
        step("z_run", 0, 0, 1, 1, 1, 0);
        step("z_frozen", 0, 0, 1, 1, 1, 0);
        cfg_valid = 1'b1; cfg_step = 32'd500; cfg_sync = 1'b1;
        step("z_sync_imm", 0, 1, 0, 0, 0, 0);
        cfg_valid = 1'b0;
        step("z_clr", 0, 0, 0, 0, 0, 500);
        step("z_settle1", 500, 0, 0, 0, 0, 500);
        step("z_settle2", 1000, 0, 0, 0, 0, 500);
        step("z_settle3", 1500, 0, 0, 0, 0, 500);
        step("z_run2", 2000, 0, 1, 1, 1, 500);

        // Enable dropped while waiting for wrap, then an IDLE retune
        bring_up();
        cfg_valid = 1'b1; cfg_step = S3; cfg_sync = 1'b1;
        ph += D;
        step("ww_req", ph, 0, 1, 0, 0, D);
        cfg_valid = 1'b0;
        ph += D;
        step("ww", ph, 0, 1, 0, 0, D);
        en = 1'b0;
        step("ww_drop", 0, 0, 0, 0, 1, D);
        cfg_valid = 1'b1; cfg_step = 32'd100; cfg_sync = 1'b1;
        step("idle_xfer", 0, 0, 0, 0, 1, 100);
        cfg_valid = 1'b0;
        step("idle_hold", 0, 0, 0, 0, 1, 100);

        // Enable drop coincident with a RUN transfer keeps the new step
        bring_up();
        en = 1'b0; cfg_valid = 1'b1; cfg_step = 32'd777; cfg_sync = 1'b0;
        step("run_off_xfer", 0, 0, 0, 0, 1, 777);
        cfg_valid = 1'b0;

        // Reset while settling after a retune
        bring_up();
        cfg_valid = 1'b1; cfg_step = S2; cfg_sync = 1'b0;
        ph += D;
        step("r_apply", ph, 1, 0, 0, 0, D);
        cfg_valid = 1'b0;
        step("r_clr", 0, 0, 0, 0, 0, S2);
        step("r_settle", S2, 0, 0, 0, 0, S2);
        reset = 1'b1; en = 1'b0;
        step("r_reset", 0, 0, 0, 0, 1, D);
        reset = 1'b0;
        step("r_idle", 0, 0, 0, 0, 1, D);

        repeat (3) @(posedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
